eth_frame_fifo: RTL and testbench

ETH_FRAME_FIFO -- requirements
Module: eth_frame_fifo

---
 rtl/eth_fifo_pkg.sv | 29 ++
 rtl/eth_fifo_sdpram.sv | 30 +++
 rtl/eth_frame_fifo.sv | 254 +++++++++++++++++++++++++
 tb/tb_eth_frame_fifo.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_fifo_pkg.sv
// Shared types for the Ethernet store-and-forward frame FIFO:
// write/read FSM encodings and the committed-frame descriptor.
package eth_fifo_pkg;

    // Descriptor fields are sized for the widest supported build
    // (ADDR_WIDTH <= 16, DATA_WIDTH <= 128); instances use the low bits.
    localparam int DESC_PTR_W  = 17;
    localparam int DESC_KEEP_W = 16;
    localparam int STAT_W      = 16;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_DATA,
        WR_CRC,
        WR_DROP
    } wr_state_e;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_LOAD,
        RD_BURST
    } rd_state_e;

    typedef struct packed {
        logic [DESC_PTR_W-1:0]  end_ptr;
        logic [DESC_KEEP_W-1:0] keep;
    } desc_t;

endpackage

// File: rtl/eth_fifo_sdpram.sv
// Simple dual-port beat memory, one write port, one registered read port.
// Ports: aclk; we/waddr/wdata write; re/raddr read, rdata updates only when re=1.
module eth_fifo_sdpram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                                aclk,
    input  logic                                we,
    input  logic [ADDR_WIDTH-1:0]               waddr,
    input  logic [DATA_WIDTH+DATA_WIDTH/8-1:0]  wdata,
    input  logic                                re,
    input  logic [ADDR_WIDTH-1:0]               raddr,
    output logic [DATA_WIDTH+DATA_WIDTH/8-1:0]  rdata
);

    localparam int MW = DATA_WIDTH + DATA_WIDTH / 8;

    logic [MW-1:0] mem [2**ADDR_WIDTH];

    // rdata holds while re=0, which keeps egress data stable during stalls
    always_ff @(posedge aclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/eth_frame_fifo.sv
// Store-and-forward Ethernet frame FIFO: frames become visible on m_axis only
// after a CRC-good commit; bad, timed-out or overflowing frames are discarded.
// Ports: aclk, areset (sync, active-high); crc_ok/crc_bad verdict pulses;
// s_axis_* ingress; m_axis_* egress; frame_count; drop_pulse.
// Optional ETH_FIFO_STATS_EN adds stat_drop_crc / stat_drop_ovf counters.
module eth_frame_fifo
    import eth_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int FRAME_DEPTH = 8,
    parameter int CRC_TIMEOUT = 8
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          crc_ok,
    input  logic                          crc_bad,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]       s_axis_tkeep,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tlast,
    output logic                          s_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]       m_axis_tkeep,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
`ifdef ETH_FIFO_STATS_EN
    output logic [STAT_W-1:0]             stat_drop_crc,
    output logic [STAT_W-1:0]             stat_drop_ovf,
`endif
    output logic [$clog2(FRAME_DEPTH):0]  frame_count,
    output logic                          drop_pulse
);

    localparam int KW  = DATA_WIDTH / 8;
    localparam int MW  = DATA_WIDTH + KW;
    localparam int PW  = ADDR_WIDTH + 1;
    localparam int FW  = $clog2(FRAME_DEPTH);
    localparam int TW  = $clog2(CRC_TIMEOUT + 1);

    wr_state_e wr_state, wr_next;
    rd_state_e rd_state, rd_next;

    logic [PW-1:0]   wr_ptr, commit_ptr, rd_ptr, used, cur_end;
    logic [TW-1:0]   crc_tmr;
    logic [KW-1:0]   last_keep, cur_keep;
    logic [FW:0]     desc_wp, desc_rp;
    desc_t           desc_mem [FRAME_DEPTH];
    desc_t           desc_d, desc_q;
    logic [MW-1:0]   mem_dout;
    logic [ADDR_WIDTH-1:0] raddr;

    logic mem_full, desc_full, desc_empty, accept;
    logic mem_we, commit, drop_crc, drop_ovf;
    logic rd_en, pop, hs, last_hs, beat_last;
    logic unused_bits;

    assign used       = wr_ptr - rd_ptr;
    assign mem_full   = used == PW'(2**ADDR_WIDTH);
    // Capacity is bounded by frames not yet fully read, including the
    // one currently streaming out, not just by queued descriptors.
    assign desc_full  = frame_count == (FW+1)'(FRAME_DEPTH);
    assign desc_empty = desc_wp == desc_rp;
    assign desc_q     = desc_mem[desc_rp[FW-1:0]];
    assign desc_d     = '{end_ptr: DESC_PTR_W'(wr_ptr),
                          keep:    DESC_KEEP_W'(last_keep)};
    assign unused_bits = ^{desc_q, mem_dout[MW-1:DATA_WIDTH]};

    // ---------------- write side ----------------
    always_comb begin
        wr_next       = wr_state;
        mem_we        = 1'b0;
        commit        = 1'b0;
        drop_crc      = 1'b0;
        drop_ovf      = 1'b0;
        s_axis_tready = ~areset & (wr_state != WR_CRC);
        accept        = s_axis_tvalid & s_axis_tready;
        unique case (wr_state)
            WR_IDLE, WR_DATA: begin
                if (accept) begin
                    if (mem_full) begin
                        if (s_axis_tlast) begin
                            drop_ovf = 1'b1;
                            wr_next  = WR_IDLE;
                        end else begin
                            wr_next  = WR_DROP;
                        end
                    end else begin
                        mem_we  = 1'b1;
                        wr_next = s_axis_tlast ? WR_CRC : WR_DATA;
                    end
                end
            end
            WR_DROP: begin
                if (accept && s_axis_tlast) begin
                    drop_ovf = 1'b1;
                    wr_next  = WR_IDLE;
                end
            end
            WR_CRC: begin
                if (crc_bad ||
                    (!crc_ok && crc_tmr == TW'(CRC_TIMEOUT - 1))) begin
                    drop_crc = 1'b1;
                    wr_next  = WR_IDLE;
                end else if (crc_ok) begin
                    drop_ovf = desc_full;
                    commit   = ~desc_full;
                    wr_next  = WR_IDLE;
                end
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_state   <= WR_IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            crc_tmr    <= '0;
            last_keep  <= '0;
            desc_wp    <= '0;
            drop_pulse <= 1'b0;
        end else begin
            wr_state   <= wr_next;
            drop_pulse <= drop_crc | drop_ovf;
            crc_tmr    <= (wr_state == WR_CRC) ? crc_tmr + 1'b1 : '0;
            if (mem_we) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (s_axis_tlast) begin
                    last_keep <= s_axis_tkeep;
                end
            end
            if (drop_crc || drop_ovf) begin
                wr_ptr <= commit_ptr;
            end
            if (commit) begin
                commit_ptr <= wr_ptr;
                desc_wp    <= desc_wp + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (commit) begin
            desc_mem[desc_wp[FW-1:0]] <= desc_d;
        end
    end

    // ---------------- read side ----------------
    // rd_ptr addresses the beat held in the memory output register;
    // the next beat is fetched on the same cycle as each handshake.
    always_comb begin
        rd_next       = rd_state;
        rd_en         = 1'b0;
        raddr         = rd_ptr[ADDR_WIDTH-1:0];
        pop           = 1'b0;
        hs            = 1'b0;
        last_hs       = 1'b0;
        m_axis_tvalid = (rd_state == RD_BURST);
        beat_last     = (rd_ptr + 1'b1) == cur_end;
        unique case (rd_state)
            RD_IDLE: begin
                if (!desc_empty) rd_next = RD_LOAD;
            end
            RD_LOAD: begin
                pop     = 1'b1;
                rd_en   = 1'b1;
                rd_next = RD_BURST;
            end
            RD_BURST: begin
                if (m_axis_tready) begin
                    hs = 1'b1;
                    if (beat_last) begin
                        last_hs = 1'b1;
                        rd_next = desc_empty ? RD_IDLE : RD_LOAD;
                    end else begin
                        rd_en = 1'b1;
                        raddr = ADDR_WIDTH'(rd_ptr + 1'b1);
                    end
                end
            end
            default: rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            rd_state <= RD_IDLE;
            rd_ptr   <= '0;
            desc_rp  <= '0;
            cur_end  <= '0;
            cur_keep <= '0;
        end else begin
            rd_state <= rd_next;
            if (pop) begin
                desc_rp  <= desc_rp + 1'b1;
                cur_end  <= desc_q.end_ptr[PW-1:0];
                cur_keep <= desc_q.keep[KW-1:0];
            end
            if (hs) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign m_axis_tlast = m_axis_tvalid & beat_last;
    assign m_axis_tdata = m_axis_tvalid ? mem_dout[DATA_WIDTH-1:0] : '0;
    assign m_axis_tkeep = !m_axis_tvalid ? '0 :
                          beat_last      ? cur_keep : '1;

    always_ff @(posedge aclk) begin
        if (areset) begin
            frame_count <= '0;
        end else begin
            unique case ({commit, last_hs})
                2'b10:   frame_count <= frame_count + 1'b1;
                2'b01:   frame_count <= frame_count - 1'b1;
                default: frame_count <= frame_count;
            endcase
        end
    end

`ifdef ETH_FIFO_STATS_EN
    always_ff @(posedge aclk) begin
        if (areset) begin
            stat_drop_crc <= '0;
            stat_drop_ovf <= '0;
        end else begin
            if (drop_crc && stat_drop_crc != '1) begin
                stat_drop_crc <= stat_drop_crc + 1'b1;
            end
            if (drop_ovf && stat_drop_ovf != '1) begin
                stat_drop_ovf <= stat_drop_ovf + 1'b1;
            end
        end
    end
`endif

    eth_fifo_sdpram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .aclk  (aclk),
        .we    (mem_we),
        .waddr (wr_ptr[ADDR_WIDTH-1:0]),
        .wdata ({s_axis_tkeep, s_axis_tdata}),
        .re    (rd_en),
        .raddr (raddr),
        .rdata (mem_dout)
    );

endmodule

// File: tb/tb_eth_frame_fifo.sv
// Bench for eth_frame_fifo: directed frames against a queue-based
// model of committed beats, checked every cycle on the falling edge.
module tb_eth_frame_fifo;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        crc_ok = 1'b0;
    logic        crc_bad = 1'b0;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tkeep = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready = 1'b1;
    logic [3:0]  frame_count;
    logic        drop_pulse;
`ifdef ETH_FIFO_STATS_EN
    logic [15:0] stat_drop_crc, stat_drop_ovf;
`endif

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    beat_t exp_q[$];
    beat_t hold;
    bit    hold_v = 0;
    bit    chk_en = 0;
    int    model_fc = 0;
    int    drop_exp = 0;
    int    drop_seen = 0;
    int    out_beats = 0;
    int    rdy_mode = 1;
    int    n_cmp = 0;
    int    n_bad = 0;

    always #5 aclk = ~aclk;

    eth_frame_fifo #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (4),
        .FRAME_DEPTH (8),
        .CRC_TIMEOUT (8)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .crc_ok        (crc_ok),
        .crc_bad       (crc_bad),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
`ifdef ETH_FIFO_STATS_EN
        .stat_drop_crc (stat_drop_crc),
        .stat_drop_ovf (stat_drop_ovf),
`endif
        .frame_count   (frame_count),
        .drop_pulse    (drop_pulse)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm, input logic [63:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %0h expected none at %0t", nm, act, $time);
    endtask

    // egress ready pattern: 0 = held low, 1 = held high, 2 = toggling
    initial forever begin
        @(posedge aclk);
        #1;
        case (rdy_mode)
            0:       m_tready = 1'b0;
            1:       m_tready = 1'b1;
            default: m_tready = ~m_tready;
        endcase
    end

    // compare process
    always @(negedge aclk) begin
        if (!chk_en) begin
            hold_v = 0;
        end else begin
            chk("frame_count", frame_count, model_fc);
            if (drop_pulse) drop_seen++;
            if (!m_tvalid) chk("idle_tlast", m_tlast, 0);
            if (hold_v) begin
                chk("stall_valid", m_tvalid, 1);
                chk("stall_data", m_tdata, hold.d);
                chk("stall_keep", m_tkeep, hold.k);
                chk("stall_last", m_tlast, hold.l);
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_beat", m_tdata);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", m_tdata, e.d);
                    chk("beat_keep", m_tkeep, e.k);
                    chk("beat_last", m_tlast, e.l);
                    if (e.l) model_fc--;
                end
                out_beats++;
                hold_v = 0;
            end else if (m_tvalid) begin
                hold_v = 1;
                hold   = '{m_tdata, m_tkeep, m_tlast};
            end else begin
                hold_v = 0;
            end
        end
    end

    // verdict: 0 = crc_ok, 1 = crc_bad, 2 = none (timeout)
    task automatic send_frame(input int n, input logic [31:0] base,
                              input logic [3:0] lk, input int verdict,
                              input int dly, input bit commit);
        beat_t fb[$];
        bit    acc;
        int    guard;
        int    zeros;
        for (int i = 0; i < n; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = base + i * 32'h11;
            s_tkeep  = (i == n - 1) ? lk : 4'hF;
            s_tlast  = (i == n - 1);
            fb.push_back('{s_tdata, s_tkeep, s_tlast});
            acc   = 0;
            guard = 0;
            while (!acc) begin
                @(negedge aclk);
                acc = s_tready;
                @(posedge aclk);
                #1;
                guard++;
                if (!acc && guard > 40) begin
                    fail_now("s_tready_timeout", 0);
                    acc = 1;
                end
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if (verdict == 2) begin
            zeros = 0;
            for (int k = 0; k < 12; k++) begin
                @(negedge aclk);
                if (s_tready) break;
                zeros++;
            end
            chk("timeout_ready_low_cycles", zeros, 8);
            drop_exp++;
            @(posedge aclk);
            #1;
        end else begin
            repeat (dly - 1) begin
                @(posedge aclk);
                #1;
            end
            if (verdict == 0) crc_ok = 1'b1;
            else              crc_bad = 1'b1;
            @(posedge aclk);
            if (verdict == 0 && commit) begin
                foreach (fb[i]) exp_q.push_back(fb[i]);
                model_fc++;
            end else begin
                drop_exp++;
            end
            #1;
            crc_ok  = 1'b0;
            crc_bad = 1'b0;
        end
    endtask

    task automatic drain(input string nm);
        int g = 0;
        while ((exp_q.size() != 0 || model_fc != 0) && g < 300) begin
            @(posedge aclk);
            g++;
        end
        repeat (4) @(posedge aclk);
        #1;
        chk({nm, "_drained"}, exp_q.size(), 0);
        chk({nm, "_drops"}, drop_seen, drop_exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        // reset state
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_m_tkeep", m_tkeep, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_drop", drop_pulse, 0);
        chk("rst_frame_count", frame_count, 0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        chk_en = 1;
        @(negedge aclk);
        chk("post_rst_s_tready", s_tready, 1);
        @(posedge aclk);
        #1;

        // 4-beat good frame, verdict 2 cycles after tlast
        send_frame(4, 32'h11, 4'h3, 0, 2, 1);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge aclk);
            if (k == 1) chk("fc_after_commit", frame_count, 1);
            lat = k;
            if (m_tvalid) break;
        end
        chk("first_beat_latency", lat, 3);
        chk("first_beat_data", m_tdata, 32'h11);
        drain("good4");
        chk("good4_beats_out", out_beats, 4);

        // crc_bad frame, then a good frame
        send_frame(4, 32'h11, 4'h3, 1, 2, 0);
        send_frame(4, 32'h55, 4'hF, 0, 1, 1);
        drain("bad_then_good");
        chk("bad_then_good_beats_out", out_beats, 8);

        // no verdict -> timeout drop, then a good frame
        send_frame(3, 32'hA0, 4'h1, 2, 0, 0);
        send_frame(2, 32'hB0, 4'h7, 0, 3, 1);
        drain("timeout");

        // 20-beat frame overflows a 16-beat memory; late crc_ok ignored
        send_frame(20, 32'h100, 4'hF, 0, 1, 0);
        drain("overflow");
        // full-size frame with toggling ready, wrapping the pointers
        rdy_mode = 2;
        send_frame(16, 32'h200, 4'h8, 0, 1, 1);
        drain("wrap16");
        chk("wrap16_beats_out", out_beats, 26);
        rdy_mode = 1;

        // 9 one-beat frames with egress stalled: 9th has no descriptor room
        rdy_mode = 0;
        for (int f = 0; f < 9; f++) begin
            send_frame(1, 32'h1000 * (f + 1), 4'hF, 0, 1, f < 8);
        end
        @(negedge aclk);
        chk("desc_full_frame_count", frame_count, 8);
        @(posedge aclk);
        #1;
        rdy_mode = 1;
        drain("desc_full");
        chk("desc_full_beats_out", out_beats, 34);

        // reset with committed and partial frames held
        rdy_mode = 0;
        send_frame(2, 32'h500, 4'h3, 0, 1, 1);
        send_frame(2, 32'h600, 4'h3, 0, 1, 1);
        s_tvalid = 1'b1;
        s_tdata  = 32'h6666;
        s_tkeep  = 4'hF;
        s_tlast  = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
        chk_en   = 0;
        areset   = 1'b1;
        exp_q.delete();
        model_fc = 0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("mid_rst_frame_count", frame_count, 0);
        chk("mid_rst_m_tvalid", m_tvalid, 0);
        chk("mid_rst_drop", drop_pulse, 0);
        @(posedge aclk);
        #1;
        areset   = 1'b0;
        chk_en   = 1;
        rdy_mode = 1;
        repeat (6) @(posedge aclk);
        #1;
        send_frame(3, 32'h700, 4'h1, 0, 2, 1);
        drain("after_reset");
        chk("total_beats_out", out_beats, 37);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
